// File: rtl/aes_inv_round_sequencer_if.sv
// Bundle of the sequencer's upstream, key-store, datapath and downstream signals.
// master = sequencer side, slave = surrounding environment side.
interface aes_inv_round_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;

    logic         key_req;
    logic [3:0]   key_idx;
    logic         key_valid;
    logic [127:0] key_in;

    logic [127:0] dp_state;
    logic [127:0] dp_key;
    logic         dp_mix_en;
    logic [127:0] dp_result;

    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    logic         busy;

    modport master (
        input  in_valid, in_data, key_valid, key_in, dp_result, out_ready,
        output in_ready, key_req, key_idx, dp_state, dp_key, dp_mix_en,
               out_valid, out_data, busy
    );

    modport slave (
        output in_valid, in_data, key_valid, key_in, dp_result, out_ready,
        input  in_ready, key_req, key_idx, dp_state, dp_key, dp_mix_en,
               out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_inv_round_sequencer.sv
// AES-128 block decryption sequencer: owns the state register, walks round keys
// 10..0 from the key store and steps the external inverse-round datapath.
module aes_inv_round_sequencer #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    aes_inv_round_sequencer_if.master     bus
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE,
        KEY,
        DONE
    } fsm_t;

    fsm_t         r_fsm_reg;
    fsm_t         w_fsm_next;
    logic [3:0]   r_round_idx_reg;
    logic [3:0]   w_round_idx_next;
    logic [127:0] r_state_reg;
    logic [127:0] w_state_next;

    logic         w_in_ready;
    logic         w_key_req;
    logic         w_mix_en;
    logic         w_out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm_reg       <= IDLE;
            r_round_idx_reg <= LAST_IDX;
            r_state_reg     <= '0;
        end else begin
            r_fsm_reg       <= w_fsm_next;
            r_round_idx_reg <= w_round_idx_next;
            r_state_reg     <= w_state_next;
        end
    end

    always_comb begin
        w_fsm_next       = r_fsm_reg;
        w_round_idx_next = r_round_idx_reg;
        w_state_next     = r_state_reg;
        w_in_ready       = 1'b0;
        w_key_req        = 1'b0;
        w_mix_en         = 1'b0;
        w_out_valid      = 1'b0;

        case (r_fsm_reg)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next     = bus.in_data;
                    w_round_idx_next = LAST_IDX;
                    w_fsm_next       = KEY;
                end
            end

            KEY: begin
                w_key_req = 1'b1;
                // Mix columns only in the middle rounds; first and last skip it.
                w_mix_en  = (r_round_idx_reg != 4'd0) && (r_round_idx_reg != LAST_IDX);
                if (bus.key_valid) begin
                    // The first key is a plain AddRoundKey, so the datapath is bypassed.
                    if (r_round_idx_reg == LAST_IDX) begin
                        w_state_next = r_state_reg ^ bus.key_in;
                    end else begin
                        w_state_next = bus.dp_result;
                    end

                    if (r_round_idx_reg == 4'd0) begin
                        w_fsm_next = DONE;
                    end else begin
                        w_round_idx_next = r_round_idx_reg - 4'd1;
                    end
                end
            end

            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_fsm_next       = IDLE;
                    w_round_idx_next = LAST_IDX;
                end
            end

            default: begin
                w_fsm_next       = IDLE;
                w_round_idx_next = LAST_IDX;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.key_req   = w_key_req;
    assign bus.key_idx   = r_round_idx_reg;
    assign bus.dp_mix_en = w_mix_en;
    assign bus.dp_state  = r_state_reg;
    assign bus.dp_key    = bus.key_in;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_state_reg;
    assign bus.busy      = (r_fsm_reg != IDLE);

endmodule
